pwm_reg_commit_ctrl: RTL and testbench

Sits between the SPI peripheral frontend and the PWM generator. Accepts decoded SPI write frames through a valid/ready handshake and validates the R/W bit and address. Valid frames are staged in shadow registers. All staged registers are committed to the active PWM configuration registers together, on a PWM period boundary, so the PWM never sees a torn or mid-period update.

---
 rtl/pwm_reg_commit_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_reg_commit_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_reg_commit_ctrl.sv
// pwm_reg_commit_ctrl
// Takes decoded SPI write frames and stages them in shadow registers. All
// staged registers are copied to the active PWM configuration registers
// together in one cycle, so the PWM generator never sees a half-updated
// configuration.
//
// Build option: PWM_SYNC_COMMIT_EN
//   defined   - commits wait for the next period_end pulse
//   undefined - each valid frame is committed right after it is checked;
//               period_end is unused
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid/wr_ready   frame handshake from the SPI frontend
//   wr_rw               1 = write, 0 = read (reads are dropped)
//   wr_addr, wr_data    register address and data of the frame
//   period_end          one-cycle pulse on the last clk of a PWM period
//   en_out_7_0 .. pwm_duty  active registers 0x00 .. 0x04
//   pending             at least one staged register awaits commit
//   commit_pulse        high in the cycle the active registers load
//   err_pulse           high in the cycle a frame is dropped
//   drop_count          saturating count of dropped frames
//
// The five active-register ports assume MAX_ADDR >= 4.
module pwm_reg_commit_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_ADDR = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_rw,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              period_end,
  output logic [DATA_W-1:0] en_out_7_0,
  output logic [DATA_W-1:0] en_out_15_8,
  output logic [DATA_W-1:0] en_pwm_7_0,
  output logic [DATA_W-1:0] en_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty,
  output logic              pending,
  output logic              commit_pulse,
  output logic              err_pulse,
  output logic [7:0]        drop_count
);

  localparam int NREG = MAX_ADDR + 1;

  typedef enum logic [1:0] {IDLE, CHECK, STAGED, COMMIT} state_t;

  state_t state_q, state_d;

  logic              fb_rw;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              frame_pend_q;
  logic [NREG-1:0]   dirty_q;
  logic [DATA_W-1:0] shadow_q [NREG];
  logic [DATA_W-1:0] active_q [NREG];
  logic [7:0]        drop_count_q;

  logic frame_ok;
  logic latch_frame;
  logic set_pend;
  logic stage_wr;
  logic commit_req;

  // Full-width unsigned compare, so e.g. 0x7F is rejected.
  assign frame_ok = fb_rw && (fb_addr <= ADDR_W'(MAX_ADDR));

`ifdef PWM_SYNC_COMMIT_EN
  logic pe_seen_q;

  // A period_end that lands while a frame is being checked is remembered
  // so the commit it asked for is not lost.
  assign commit_req = period_end || pe_seen_q;

  // pe_seen is only meaningful while staging; IDLE has nothing to commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_seen_q <= 1'b0;
    end else if (state_q == CHECK && period_end) begin
      pe_seen_q <= 1'b1;
    end else if (state_q == IDLE || (state_q == STAGED && commit_req)) begin
      pe_seen_q <= 1'b0;
    end
  end
`else
  logic unused_period_end;

  // STAGED is unreachable here; commit anything found there immediately.
  assign commit_req        = 1'b1;
  assign unused_period_end = period_end;
`endif

  // Next-state and Moore outputs. wr_ready depends only on the state.
  always_comb begin
    state_d      = state_q;
    wr_ready     = 1'b0;
    err_pulse    = 1'b0;
    commit_pulse = 1'b0;
    latch_frame  = 1'b0;
    set_pend     = 1'b0;
    stage_wr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          latch_frame = 1'b1;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (frame_ok) begin
          stage_wr = 1'b1;
`ifdef PWM_SYNC_COMMIT_EN
          state_d  = STAGED;
`else
          state_d  = COMMIT;
`endif
        end else begin
          err_pulse = 1'b1;
          state_d   = (|dirty_q) ? STAGED : IDLE;
        end
      end
      STAGED: begin
        wr_ready = 1'b1;
        if (commit_req) begin
          // The commit wins; a frame accepted in this same cycle is parked
          // and checked after the commit so it is not part of it.
          state_d = COMMIT;
          if (wr_valid) begin
            latch_frame = 1'b1;
            set_pend    = 1'b1;
          end
        end else if (wr_valid) begin
          latch_frame = 1'b1;
          state_d     = CHECK;
        end
      end
      COMMIT: begin
        commit_pulse = 1'b1;
        state_d      = frame_pend_q ? CHECK : IDLE;
      end
    endcase
  end

  // State, frame buffer, shadow/active registers and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fb_rw        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      frame_pend_q <= 1'b0;
      dirty_q      <= '0;
      drop_count_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (latch_frame) begin
        fb_rw   <= wr_rw;
        fb_addr <= wr_addr;
        fb_data <= wr_data;
      end
      if (set_pend) begin
        frame_pend_q <= 1'b1;
      end else if (commit_pulse) begin
        frame_pend_q <= 1'b0;
      end
      if (err_pulse && drop_count_q != 8'hFF) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
      // Only dirty registers are copied; clean ones keep their value.
      for (int i = 0; i < NREG; i++) begin
        if (stage_wr && fb_addr == ADDR_W'(i)) begin
          shadow_q[i] <= fb_data;
          dirty_q[i]  <= 1'b1;
        end
        if (commit_pulse && dirty_q[i]) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (commit_pulse) begin
        dirty_q <= '0;
      end
    end
  end

  assign pending     = |dirty_q;
  assign drop_count  = drop_count_q;
  assign en_out_7_0  = active_q[0];
  assign en_out_15_8 = active_q[1];
  assign en_pwm_7_0  = active_q[2];
  assign en_pwm_15_8 = active_q[3];
  assign pwm_duty    = active_q[4];

endmodule

// File: tb/tb_pwm_reg_commit_ctrl.sv
// Testbench for pwm_reg_commit_ctrl. Works in both builds (with or without
// PWM_SYNC_COMMIT_EN). Frames are grouped into batches; the reference model
// says that after a batch and one period_end every register holds the last
// valid write of that batch (or its old value), that the number of commits
// is one per batch (sync) or one per valid frame (immediate), and that
// drop_count is the saturated number of rejected frames.
module tb_pwm_reg_commit_ctrl;

`ifdef PWM_SYNC_COMMIT_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rw = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       period_end = 1'b0;
  logic [7:0] en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, pwm_duty;
  logic       pending, commit_pulse, err_pulse;
  logic [7:0] drop_count;

  pwm_reg_commit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rw(wr_rw), .wr_addr(wr_addr), .wr_data(wr_data),
    .period_end(period_end), .en_out_7_0(en_out_7_0),
    .en_out_15_8(en_out_15_8), .en_pwm_7_0(en_pwm_7_0),
    .en_pwm_15_8(en_pwm_15_8), .pwm_duty(pwm_duty), .pending(pending),
    .commit_pulse(commit_pulse), .err_pulse(err_pulse),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int commit_seen = 0;
  int err_seen = 0;

  // Reference model state
  logic [7:0] exp_active [5];
  int         exp_drops = 0;
  logic [7:0] batch_val [5];
  bit         batch_touch [5];
  int         nvalid, nbad, c0, e0;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (commit_pulse === 1'b1) commit_seen++;
    if (err_pulse === 1'b1) err_seen++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkActives(input string tag);
    checkOutput({tag, "/en_out_7_0"},  en_out_7_0,  exp_active[0]);
    checkOutput({tag, "/en_out_15_8"}, en_out_15_8, exp_active[1]);
    checkOutput({tag, "/en_pwm_7_0"},  en_pwm_7_0,  exp_active[2]);
    checkOutput({tag, "/en_pwm_15_8"}, en_pwm_15_8, exp_active[3]);
    checkOutput({tag, "/pwm_duty"},    pwm_duty,    exp_active[4]);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge right after the transfer.
  task automatic applyStimulus(input logic rw, input logic [6:0] a,
                               input logic [7:0] d);
    int waited;
    waited   = 0;
    wr_valid = 1'b1;
    wr_rw    = rw;
    wr_addr  = a;
    wr_data  = d;
    while (wr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulsePeriod();
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
  endtask

  task automatic beginBatch();
    for (int i = 0; i < 5; i++) batch_touch[i] = 1'b0;
    nvalid = 0;
    nbad   = 0;
    c0     = commit_seen;
    e0     = err_seen;
  endtask

  task automatic sendModel(input logic rw, input logic [6:0] a,
                           input logic [7:0] d);
    applyStimulus(rw, a, d);
    if (rw && a <= 7'd4) begin
      batch_val[a]   = d;
      batch_touch[a] = 1'b1;
      nvalid++;
    end else begin
      nbad++;
      if (exp_drops < 255) exp_drops++;
    end
  endtask

  task automatic applyBatch();
    for (int i = 0; i < 5; i++)
      if (batch_touch[i]) exp_active[i] = batch_val[i];
  endtask

  task automatic endBatch(input string tag);
    int exp_commits;
    waitCycles(3);
    if (!SYNC) applyBatch();
    checkOutput({tag, "/pending_pre"}, {31'd0, pending},
                (SYNC && nvalid > 0) ? 32'd1 : 32'd0);
    checkActives({tag, "/pre"});
    pulsePeriod();
    waitCycles(3);
    applyBatch();
    exp_commits = SYNC ? ((nvalid > 0) ? 1 : 0) : nvalid;
    checkActives({tag, "/post"});
    checkOutput({tag, "/commits"}, commit_seen - c0, exp_commits);
    checkOutput({tag, "/errs"}, err_seen - e0, nbad);
    checkOutput({tag, "/drop_count"}, drop_count, exp_drops);
    checkOutput({tag, "/pending_post"}, {31'd0, pending}, 32'd0);
  endtask

  initial begin
    logic       rw;
    logic [6:0] a;
    int         n;

    for (int i = 0; i < 5; i++) exp_active[i] = 8'h00;
    $display("[TB] start, sync commit = %0d", SYNC);

    // Reset state
    waitCycles(3);
    checkActives("reset");
    checkOutput("reset/pending", {31'd0, pending}, 32'd0);
    checkOutput("reset/commit_pulse", {31'd0, commit_pulse}, 32'd0);
    checkOutput("reset/err_pulse", {31'd0, err_pulse}, 32'd0);
    checkOutput("reset/drop_count", drop_count, 32'd0);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("idle/wr_ready", {31'd0, wr_ready}, 32'd1);

`ifdef PWM_SYNC_COMMIT_EN
    // Staged value stays hidden until the period boundary
    beginBatch();
    sendModel(1'b1, 7'h04, 8'hA5);
    waitCycles(1);
    for (int k = 0; k < 20; k++) begin
      checkOutput("hold/pwm_duty", pwm_duty, 32'h00);
      checkOutput("hold/pending", {31'd0, pending}, 32'd1);
      @(negedge clk);
    end
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    checkOutput("hold/commit_pulse", {31'd0, commit_pulse}, 32'd1);
    checkOutput("hold/pwm_duty_at_commit", pwm_duty, 32'h00);
    @(negedge clk);
    applyBatch();
    checkOutput("hold/pwm_duty_after", pwm_duty, 32'hA5);
    checkOutput("hold/pending_after", {31'd0, pending}, 32'd0);
    checkOutput("hold/commits", commit_seen - c0, 32'd1);
`else
    // Immediate commit: active two edges after the transfer edge
    beginBatch();
    sendModel(1'b1, 7'h04, 8'h80);
    checkOutput("imm/pwm_duty_check", pwm_duty, 32'h00);
    @(negedge clk);
    checkOutput("imm/commit_pulse", {31'd0, commit_pulse}, 32'd1);
    checkOutput("imm/pending", {31'd0, pending}, 32'd1);
    checkOutput("imm/pwm_duty_commit", pwm_duty, 32'h00);
    @(negedge clk);
    applyBatch();
    checkOutput("imm/pwm_duty_after", pwm_duty, 32'h80);
    checkOutput("imm/pending_after", {31'd0, pending}, 32'd0);
`endif

    // Last write wins, several registers in one commit
    beginBatch();
    sendModel(1'b1, 7'h02, 8'hFF);
    sendModel(1'b1, 7'h02, 8'h0F);
    sendModel(1'b1, 7'h00, 8'h3C);
    endBatch("multi");

    // Bad address and read frame are dropped
    beginBatch();
    sendModel(1'b1, 7'h05, 8'h11);
    sendModel(1'b0, 7'h01, 8'h22);
    endBatch("drop");

    // Randomized batches
    for (int b = 0; b < 8; b++) begin
      beginBatch();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        rw = ($urandom_range(0, 3) != 0);
        a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                         : 7'($urandom_range(0, 4));
        sendModel(rw, a, 8'($urandom));
      end
      endBatch("rand");
    end

    // drop_count saturation, including address 0x7F
    beginBatch();
    sendModel(1'b1, 7'h7F, 8'h01);
    for (int k = 0; k < 256; k++) begin
      if (k % 2 == 0) sendModel(1'b0, 7'($urandom_range(0, 4)), 8'($urandom));
      else            sendModel(1'b1, 7'($urandom_range(5, 127)), 8'($urandom));
    end
    endBatch("saturate");

`ifdef PWM_SYNC_COMMIT_EN
    // Frame arriving together with period_end is held for the next commit
    beginBatch();
    sendModel(1'b1, 7'h02, 8'h5A);
    waitCycles(2);
    checkOutput("coinc/wr_ready", {31'd0, wr_ready}, 32'd1);
    c0 = commit_seen;
    wr_valid   = 1'b1;
    wr_rw      = 1'b1;
    wr_addr    = 7'h01;
    wr_data    = 8'h77;
    period_end = 1'b1;
    @(negedge clk);
    wr_valid   = 1'b0;
    period_end = 1'b0;
    checkOutput("coinc/commit_pulse", {31'd0, commit_pulse}, 32'd1);
    waitCycles(3);
    applyBatch();
    checkActives("coinc/first");
    checkOutput("coinc/pending", {31'd0, pending}, 32'd1);
    pulsePeriod();
    waitCycles(3);
    exp_active[1] = 8'h77;
    checkActives("coinc/second");
    checkOutput("coinc/commits", commit_seen - c0, 32'd2);
`endif

    // Reset before the staged write commits
    applyStimulus(1'b1, 7'h03, 8'h12);
    waitCycles(SYNC ? 2 : 0);
    rst_n = 1'b0;
    waitCycles(2);
    for (int i = 0; i < 5; i++) exp_active[i] = 8'h00;
    exp_drops = 0;
    checkActives("midreset");
    checkOutput("midreset/pending", {31'd0, pending}, 32'd0);
    checkOutput("midreset/drop_count", drop_count, 32'd0);
    rst_n = 1'b1;
    c0 = commit_seen;
    waitCycles(1);
    pulsePeriod();
    waitCycles(3);
    checkOutput("midreset/commits", commit_seen - c0, 32'd0);
    checkActives("midreset/after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
